// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the column-command (CAS) scheduler.
//   cas_type_e     : encoding driven on cas_req (RD/WR, optional auto-precharge)
//   sched_fsm_type : scheduler FSM states
//   ELAPSED_MAX    : saturation value of the inter-CAS elapsed counter
//   DIR_RD/DIR_WR  : one-bit direction encoding used for last/next direction
//   cas_type_f     : maps direction + auto-precharge flag to cas_type_e
// ----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    RD_R  = 3'd0,
    WR_R  = 3'd1,
    RDA_R = 3'd2,
    WRA_R = 3'd3
  } cas_type_e;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_WAIT  = 2'd1,
    SCH_ISSUE = 2'd2
  } sched_fsm_type;

  // 63 means "long enough ago that no timing constraint applies"
  localparam logic [5:0] ELAPSED_MAX = 6'd63;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  function automatic cas_type_e cas_type_f(input logic dir, input logic ap);
    cas_type_e t;
    case ({dir, ap})
      2'b00:   t = RD_R;
      2'b01:   t = RDA_R;
      2'b10:   t = WR_R;
      2'b11:   t = WRA_R;
      default: t = RD_R;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ctrl_cas_gap_calc.sv
// ----------------------------------------------------------------------------
// ctrl_cas_gap_calc
// Combinational minimum CAS-to-CAS gap between the last issued command and the
// current candidate, in clock cycles.
// Ports:
//   last_dir_i : direction of the last issued CAS (DIR_RD/DIR_WR)
//   next_dir_i : direction of the candidate CAS
//   same_bg_i  : candidate targets the same bank group as the last CAS
//   cl_i       : read CAS latency
//   cwl_i      : write CAS latency
//   gap_o      : required gap (7-bit), never below 2
// ----------------------------------------------------------------------------
module ctrl_cas_gap_calc
  import ctrl_pkg::*;
#(
  parameter int T_CCD_S = 4,
  parameter int T_CCD_L = 6,
  parameter int T_WTR_S = 2,
  parameter int T_WTR_L = 6,
  parameter int BL      = 8
) (
  input  logic       last_dir_i,
  input  logic       next_dir_i,
  input  logic       same_bg_i,
  input  logic [4:0] cl_i,
  input  logic [4:0] cwl_i,
  output logic [6:0] gap_o
);

  localparam logic [6:0] CCD_S   = 7'(T_CCD_S);
  localparam logic [6:0] CCD_L   = 7'(T_CCD_L);
  localparam logic [6:0] WTR_S   = 7'(T_WTR_S);
  localparam logic [6:0] WTR_L   = 7'(T_WTR_L);
  localparam logic [6:0] HALF_BL = 7'(BL / 2);
  localparam logic [6:0] GAP_MIN = 7'd2;

  logic [6:0] cl_w;
  logic [6:0] cwl_w;
  logic [6:0] rtw_sum;
  logic [6:0] raw_gap;

  assign cl_w  = {2'b00, cl_i};
  assign cwl_w = {2'b00, cwl_i};

  // Gap selection by direction pair, then the global lower clamp
  always_comb begin
    raw_gap = 7'd0;
    // read-to-write: CL + BL/2 + 2 - CWL; compared before subtracting so a
    // large CWL can never wrap the unsigned result
    rtw_sum = cl_w + HALF_BL + 7'd2;
    if (last_dir_i == next_dir_i) begin
      raw_gap = same_bg_i ? CCD_L : CCD_S;
    end else if (last_dir_i == DIR_WR) begin
      raw_gap = cwl_w + HALF_BL + (same_bg_i ? WTR_L : WTR_S);
    end else begin
      if (rtw_sum < (cwl_w + CCD_S)) begin
        raw_gap = CCD_S;
      end else begin
        raw_gap = rtw_sum - cwl_w;
      end
    end
    gap_o = (raw_gap < GAP_MIN) ? GAP_MIN : raw_gap;
  end

endmodule

// File: rtl/ctrl_cas_sched.sv
// ----------------------------------------------------------------------------
// ctrl_cas_sched
// Column-command scheduler: arbitrates read-queue head vs write-queue head,
// enforces inter-CAS gaps (tCCD_S/L, write-to-read, read-to-write) and emits
// a one-cycle cas_rdy strobe with command type and bank group.
// Optional feature macro: CAS_AUTO_PRE_EN (adds rd_ap/wr_ap; RDA_R/WRA_R).
// Ports:
//   CK_t              : clock, posedge
//   reset             : synchronous active-high reset
//   CL, CWL           : runtime read/write CAS latencies
//   cas_hold          : blocks new issue decisions
//   rd_valid, rd_bg   : read request head; rd_ready pulses on acceptance
//   wr_valid, wr_bg   : write request head; wr_ready pulses on acceptance
//   rd_ap, wr_ap      : auto-precharge flags (CAS_AUTO_PRE_EN only)
//   cas_rdy           : one-cycle CAS issue strobe
//   cas_req           : command type (cas_type_e)
//   cas_bg            : bank group of the issued command
// ----------------------------------------------------------------------------
module ctrl_cas_sched
  import ctrl_pkg::*;
#(
  parameter int T_CCD_S    = 4,
  parameter int T_CCD_L    = 6,
  parameter int T_WTR_S    = 2,
  parameter int T_WTR_L    = 6,
  parameter int BL         = 8,
  parameter int STARVE_MAX = 4,
  parameter int BG_W       = 2
) (
  input  logic            CK_t,
  input  logic            reset,
  input  logic [4:0]      CL,
  input  logic [4:0]      CWL,
  input  logic            cas_hold,
  input  logic            rd_valid,
  input  logic [BG_W-1:0] rd_bg,
  output logic            rd_ready,
  input  logic            wr_valid,
  input  logic [BG_W-1:0] wr_bg,
  output logic            wr_ready,
`ifdef CAS_AUTO_PRE_EN
  input  logic            rd_ap,
  input  logic            wr_ap,
`endif
  output logic            cas_rdy,
  output logic [2:0]      cas_req,
  output logic [BG_W-1:0] cas_bg
);

  localparam int              STV_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_MAX);

  sched_fsm_type   state_q, state_d;
  logic [5:0]      elapsed_q, elapsed_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic            last_dir_q, last_dir_d;
  logic [BG_W-1:0] last_bg_q, last_bg_d;
  logic            cas_rdy_q, cas_rdy_d;
  logic            rd_ready_q, rd_ready_d;
  logic            wr_ready_q, wr_ready_d;
  cas_type_e       cas_req_q, cas_req_d;
  logic [BG_W-1:0] cas_bg_q, cas_bg_d;

  logic            wr_pick;
  logic            cand_valid;
  logic            cand_dir;
  logic [BG_W-1:0] cand_bg;
  logic            cand_ap;
  logic [6:0]      gap;
  logic [6:0]      elapsed_nxt;
  logic            gap_met;
  logic            issue;

  // Strict candidate selection: write only when reads are absent or starved
  always_comb begin
    wr_pick    = wr_valid && (!rd_valid || (starve_q >= STV_LIM));
    cand_valid = wr_pick || rd_valid;
    cand_dir   = wr_pick ? DIR_WR : DIR_RD;
    cand_bg    = wr_pick ? wr_bg : rd_bg;
`ifdef CAS_AUTO_PRE_EN
    cand_ap    = wr_pick ? wr_ap : rd_ap;
`else
    cand_ap    = 1'b0;
`endif
  end

  ctrl_cas_gap_calc #(
    .T_CCD_S (T_CCD_S),
    .T_CCD_L (T_CCD_L),
    .T_WTR_S (T_WTR_S),
    .T_WTR_L (T_WTR_L),
    .BL      (BL)
  ) u_gap (
    .last_dir_i (last_dir_q),
    .next_dir_i (cand_dir),
    .same_bg_i  (cand_bg == last_bg_q),
    .cl_i       (CL),
    .cwl_i      (CWL),
    .gap_o      (gap)
  );

  // Issuing now puts the strobe at elapsed+1, which must reach the gap
  assign elapsed_nxt = {1'b0, elapsed_q} + 7'd1;
  assign gap_met     = (elapsed_nxt >= gap);

  // Next-state logic and registered-output next values
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    case (state_q)
      SCH_ISSUE: begin
        state_d = SCH_IDLE;
      end
      SCH_IDLE, SCH_WAIT: begin
        if (!cand_valid || cas_hold) begin
          state_d = SCH_IDLE;
        end else if (gap_met) begin
          state_d = SCH_ISSUE;
          issue   = 1'b1;
        end else begin
          state_d = SCH_WAIT;
        end
      end
      default: begin
        state_d = SCH_IDLE;
      end
    endcase

    if (issue) begin
      elapsed_d = 6'd0;
    end else if (elapsed_q == ELAPSED_MAX) begin
      elapsed_d = ELAPSED_MAX;
    end else begin
      elapsed_d = elapsed_q + 6'd1;
    end

    // starvation counts reads issued past a waiting write
    if (!wr_valid) begin
      starve_d = '0;
    end else if (issue && (cand_dir == DIR_WR)) begin
      starve_d = '0;
    end else if (issue && (starve_q != STV_LIM)) begin
      starve_d = starve_q + {{(STV_W-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end

    cas_rdy_d  = issue;
    rd_ready_d = issue && (cand_dir == DIR_RD);
    wr_ready_d = issue && (cand_dir == DIR_WR);
    if (issue) begin
      cas_req_d  = cas_type_f(cand_dir, cand_ap);
      cas_bg_d   = cand_bg;
      last_dir_d = cand_dir;
      last_bg_d  = cand_bg;
    end else begin
      cas_req_d  = cas_req_q;
      cas_bg_d   = cas_bg_q;
      last_dir_d = last_dir_q;
      last_bg_d  = last_bg_q;
    end
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_q    <= SCH_IDLE;
      elapsed_q  <= ELAPSED_MAX;
      starve_q   <= '0;
      last_dir_q <= DIR_RD;
      last_bg_q  <= '0;
      cas_rdy_q  <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      cas_req_q  <= RD_R;
      cas_bg_q   <= '0;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      starve_q   <= starve_d;
      last_dir_q <= last_dir_d;
      last_bg_q  <= last_bg_d;
      cas_rdy_q  <= cas_rdy_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      cas_req_q  <= cas_req_d;
      cas_bg_q   <= cas_bg_d;
    end
  end

  assign cas_rdy  = cas_rdy_q;
  assign rd_ready = rd_ready_q;
  assign wr_ready = wr_ready_q;
  assign cas_req  = cas_req_q;
  assign cas_bg   = cas_bg_q;

endmodule

// File: tb/tb_ctrl_cas_sched.sv
// ----------------------------------------------------------------------------
// tb_ctrl_cas_sched
// Directed self-checking bench for ctrl_cas_sched (default parameters,
// CL=16, CWL=12 unless a scenario changes them).
// ----------------------------------------------------------------------------
module tb_ctrl_cas_sched;
  import ctrl_pkg::*;

  logic       CK_t = 1'b0;
  logic       reset;
  logic [4:0] CL;
  logic [4:0] CWL;
  logic       cas_hold;
  logic       rd_valid;
  logic [1:0] rd_bg;
  logic       rd_ready;
  logic       wr_valid;
  logic [1:0] wr_bg;
  logic       wr_ready;
`ifdef CAS_AUTO_PRE_EN
  logic       rd_ap;
  logic       wr_ap;
`endif
  logic       cas_rdy;
  logic [2:0] cas_req;
  logic [1:0] cas_bg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ctrl_cas_sched dut (
    .CK_t     (CK_t),
    .reset    (reset),
    .CL       (CL),
    .CWL      (CWL),
    .cas_hold (cas_hold),
    .rd_valid (rd_valid),
    .rd_bg    (rd_bg),
    .rd_ready (rd_ready),
    .wr_valid (wr_valid),
    .wr_bg    (wr_bg),
    .wr_ready (wr_ready),
`ifdef CAS_AUTO_PRE_EN
    .rd_ap    (rd_ap),
    .wr_ap    (wr_ap),
`endif
    .cas_rdy  (cas_rdy),
    .cas_req  (cas_req),
    .cas_bg   (cas_bg)
  );

  always #5 CK_t = ~CK_t;

  always @(posedge CK_t) cyc <= cyc + 1;

  task automatic do_reset();
    reset    = 1'b1;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    cas_hold = 1'b0;
`ifdef CAS_AUTO_PRE_EN
    rd_ap    = 1'b0;
    wr_ap    = 1'b0;
`endif
    repeat (2) @(negedge CK_t);
    reset = 1'b0;
  endtask

  // Waits (bounded) for the next cas_rdy strobe, sampled on the falling edge
  task automatic wait_rdy(input string name, output int t);
    bit found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CK_t);
      if (cas_rdy === 1'b1) begin
        found = 1'b1;
        t = cyc;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: no cas_rdy within 100 cycles (got none, required one)", name);
    end
  endtask

  task automatic present(input logic dir, input logic [1:0] bg);
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    if (dir == DIR_RD) begin
      rd_valid = 1'b1;
      rd_bg    = bg;
    end else begin
      wr_valid = 1'b1;
      wr_bg    = bg;
    end
  endtask

  // Two back-to-back requests from reset; returns strobe spacing and attributes
  task automatic run_pair(input string name,
                          input logic d1, input logic [1:0] b1,
                          input logic d2, input logic [1:0] b2,
                          output int dt, output logic [2:0] req2,
                          output logic [1:0] bg2, output logic [1:0] rdy2);
    int t1, t2;
    do_reset();
    present(d1, b1);
    wait_rdy({name, "_first"}, t1);
    present(d2, b2);
    wait_rdy({name, "_second"}, t2);
    req2 = cas_req;
    bg2  = cas_bg;
    rdy2 = {rd_ready, wr_ready};
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    dt = t2 - t1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cas_rdy, rd_ready, wr_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 000", {cas_rdy, rd_ready, wr_ready});
    end
    checks++;
    if (cas_req !== RD_R || cas_bg !== 2'd0) begin
      errors++;
      $display("FAIL reset_req_bg: got req=%0d bg=%0d required req=0 bg=0", cas_req, cas_bg);
    end
    checks++;
    if (dut.state_q !== SCH_IDLE || dut.elapsed_q !== 6'd63 || dut.starve_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d elapsed=%0d starve=%0d required 0/63/0",
               dut.state_q, dut.elapsed_q, dut.starve_q);
    end
  endtask

  task automatic test_ccd();
    int dt; logic [2:0] rq; logic [1:0] bg; logic [1:0] rdy;
    run_pair("rd_rd_same", DIR_RD, 2'd0, DIR_RD, 2'd0, dt, rq, bg, rdy);
    checks++;
    if (dt !== 6 || rq !== RD_R || rdy !== 2'b10) begin
      errors++;
      $display("FAIL rd_rd_same: got dt=%0d req=%0d rdy=%b required dt=6 req=0 rdy=10", dt, rq, rdy);
    end
    run_pair("rd_rd_diff", DIR_RD, 2'd0, DIR_RD, 2'd1, dt, rq, bg, rdy);
    checks++;
    if (dt !== 4 || bg !== 2'd1) begin
      errors++;
      $display("FAIL rd_rd_diff: got dt=%0d bg=%0d required dt=4 bg=1", dt, bg);
    end
    run_pair("wr_wr_same", DIR_WR, 2'd2, DIR_WR, 2'd2, dt, rq, bg, rdy);
    checks++;
    if (dt !== 6 || rq !== WR_R || rdy !== 2'b01 || bg !== 2'd2) begin
      errors++;
      $display("FAIL wr_wr_same: got dt=%0d req=%0d rdy=%b bg=%0d required dt=6 req=1 rdy=01 bg=2",
               dt, rq, rdy, bg);
    end
  endtask

  task automatic test_wtr();
    int dt; logic [2:0] rq; logic [1:0] bg; logic [1:0] rdy;
    run_pair("wr_rd_diff", DIR_WR, 2'd0, DIR_RD, 2'd1, dt, rq, bg, rdy);
    checks++;
    if (dt !== 18 || rq !== RD_R) begin
      errors++;
      $display("FAIL wr_rd_diff: got dt=%0d req=%0d required dt=18 req=0", dt, rq);
    end
    run_pair("wr_rd_same", DIR_WR, 2'd0, DIR_RD, 2'd0, dt, rq, bg, rdy);
    checks++;
    if (dt !== 22) begin
      errors++;
      $display("FAIL wr_rd_same: got dt=%0d required 22", dt);
    end
  endtask

  task automatic test_rtw();
    int dt; logic [2:0] rq; logic [1:0] bg; logic [1:0] rdy;
    run_pair("rd_wr_cl16", DIR_RD, 2'd0, DIR_WR, 2'd0, dt, rq, bg, rdy);
    checks++;
    if (dt !== 10 || rq !== WR_R) begin
      errors++;
      $display("FAIL rd_wr_cl16: got dt=%0d req=%0d required dt=10 req=1", dt, rq);
    end
    CL = 5'd12;
    run_pair("rd_wr_cl12", DIR_RD, 2'd0, DIR_WR, 2'd0, dt, rq, bg, rdy);
    checks++;
    if (dt !== 6) begin
      errors++;
      $display("FAIL rd_wr_cl12: got dt=%0d required 6", dt);
    end
    // 8 + 4 + 2 - 12 = 2, raised to T_CCD_S
    CL = 5'd8;
    run_pair("rd_wr_clamp", DIR_RD, 2'd0, DIR_WR, 2'd0, dt, rq, bg, rdy);
    checks++;
    if (dt !== 4) begin
      errors++;
      $display("FAIL rd_wr_clamp: got dt=%0d required 4", dt);
    end
    CL = 5'd16;
  endtask

  task automatic test_starve();
    int t, tprev;
    logic [2:0] exp_req;
    do_reset();
    wr_valid = 1'b1; wr_bg = 2'd1;
    rd_valid = 1'b1; rd_bg = 2'd0;
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rdy("starve_pulse", t);
      exp_req = (k < 4) ? RD_R : WR_R;
      checks++;
      if (cas_req !== exp_req) begin
        errors++;
        $display("FAIL starve_order_%0d: got req=%0d required %0d", k, cas_req, exp_req);
      end
      checks++;
      if (dut.starve_q !== ((k < 4) ? 3'(k + 1) : 3'd0)) begin
        errors++;
        $display("FAIL starve_cnt_%0d: got %0d required %0d", k, dut.starve_q,
                 (k < 4) ? (k + 1) : 0);
      end
      if (k > 0) begin
        checks++;
        if ((t - tprev) !== ((k < 4) ? 6 : 10)) begin
          errors++;
          $display("FAIL starve_gap_%0d: got %0d required %0d", k, t - tprev, (k < 4) ? 6 : 10);
        end
      end
      tprev = t;
      if (wr_ready === 1'b1) wr_valid = 1'b0;
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic test_hold();
    int n, tdrop, t, p;
    do_reset();
    cas_hold = 1'b1;
    rd_valid = 1'b1; rd_bg = 2'd2;
    n = 0;
    repeat (30) begin
      @(negedge CK_t);
      if (cas_rdy === 1'b1) n++;
    end
    checks++;
    if (n !== 0 || dut.state_q !== SCH_IDLE) begin
      errors++;
      $display("FAIL hold_block: got pulses=%0d state=%0d required 0/0", n, dut.state_q);
    end
    cas_hold = 1'b0;
    tdrop = cyc;
    wait_rdy("hold_release", t);
    checks++;
    if (t !== tdrop + 1) begin
      errors++;
      $display("FAIL hold_release: got delay=%0d required 1", t - tdrop);
    end
    // same-bg read waits 6; a hold pulse inside the wait must not stop elapsed
    p = t;
    repeat (2) @(negedge CK_t);
    checks++;
    if (dut.state_q !== SCH_WAIT) begin
      errors++;
      $display("FAIL hold_wait_state: got %0d required %0d", dut.state_q, SCH_WAIT);
    end
    cas_hold = 1'b1;
    @(negedge CK_t);
    checks++;
    if (dut.state_q !== SCH_IDLE || dut.elapsed_q !== 6'd3) begin
      errors++;
      $display("FAIL hold_in_wait: got state=%0d elapsed=%0d required 0/3", dut.state_q, dut.elapsed_q);
    end
    cas_hold = 1'b0;
    wait_rdy("hold_resume", t);
    checks++;
    if ((t - p) !== 6) begin
      errors++;
      $display("FAIL hold_resume_gap: got %0d required 6", t - p);
    end
    rd_valid = 1'b0;
  endtask

  task automatic test_reset_issue();
    int t, tr;
    do_reset();
    rd_valid = 1'b1; rd_bg = 2'd3;
    wait_rdy("rst_issue_first", t);
    reset = 1'b1;
    @(negedge CK_t);
    checks++;
    if ({cas_rdy, rd_ready} !== 2'b00 || dut.state_q !== SCH_IDLE || dut.elapsed_q !== 6'd63) begin
      errors++;
      $display("FAIL rst_issue_clear: got rdy=%b state=%0d elapsed=%0d required 00/0/63",
               {cas_rdy, rd_ready}, dut.state_q, dut.elapsed_q);
    end
    reset = 1'b0;
    tr = cyc;
    wait_rdy("rst_issue_again", t);
    checks++;
    if (t !== tr + 1 || cas_bg !== 2'd3 || cas_req !== RD_R) begin
      errors++;
      $display("FAIL rst_issue_again: got delay=%0d bg=%0d req=%0d required 1/3/0",
               t - tr, cas_bg, cas_req);
    end
    rd_valid = 1'b0;
  endtask

`ifdef CAS_AUTO_PRE_EN
  task automatic test_auto_pre();
    int t;
    do_reset();
    rd_ap = 1'b1; rd_valid = 1'b1; rd_bg = 2'd1;
    wait_rdy("ap_rd", t);
    checks++;
    if (cas_req !== RDA_R) begin
      errors++;
      $display("FAIL ap_rd: got req=%0d required %0d", cas_req, RDA_R);
    end
    rd_valid = 1'b0; rd_ap = 1'b0;
    wr_ap = 1'b1; wr_valid = 1'b1; wr_bg = 2'd1;
    wait_rdy("ap_wr", t);
    checks++;
    if (cas_req !== WRA_R) begin
      errors++;
      $display("FAIL ap_wr: got req=%0d required %0d", cas_req, WRA_R);
    end
    wr_valid = 1'b0; wr_ap = 1'b0;
  endtask
`endif

  initial begin
    reset    = 1'b1;
    CL       = 5'd16;
    CWL      = 5'd12;
    cas_hold = 1'b0;
    rd_valid = 1'b0;
    rd_bg    = 2'd0;
    wr_valid = 1'b0;
    wr_bg    = 2'd0;
`ifdef CAS_AUTO_PRE_EN
    rd_ap    = 1'b0;
    wr_ap    = 1'b0;
`endif
    test_reset();
    test_ccd();
    test_wtr();
    test_rtw();
    test_starve();
    test_hold();
    test_reset_issue();
`ifdef CAS_AUTO_PRE_EN
    test_auto_pre();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
